ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends single command bytes to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset), using the standard host-request sequence: inhibit, request-to-send, 11 device-clocked bits, ACK. It sits beside the existing PS/2 receive path on the same `ps2_clk`/`ps2_data` pins. The top level turns the open-drain enables into tristate drivers (pin = oe ? 0 : Z). `tx_busy` lets the receive path discard frames while a transmission is in progress.

---
 rtl/ps2_host_tx_if.sv | 28 ++
 rtl/ps2_host_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte request handshake and
// completion status for the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_busy,
    input  tx_done,
    input  tx_error
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_busy,
    output tx_done,
    output tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command sender.
// Inhibit, request-to-send, 11 device clocks, ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned REQ_CYCLES     = 200,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic ps2_clk_oe,
  output logic ps2_data_oe,
  ps2_host_tx_if.slave tx
);

  localparam int unsigned PH_MAX =
    (INHIBIT_CYCLES > REQ_CYCLES) ?
    INHIBIT_CYCLES : REQ_CYCLES;
  localparam int PW = $clog2(PH_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] INH_LAST =
    PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] REQ_LAST =
    PW'(REQ_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state_q, state_n;

  logic [PW-1:0] ph_q, ph_n;
  logic [TW-1:0] to_q, to_n;
  logic [3:0]    bit_q, bit_n;
  logic [7:0]    byte_q, byte_n;
  logic          par_q, par_n;
  logic          nack_q, nack_n;
  logic          data_oe_n;

  logic clk_s1, clk_s2, clk_p;
  logic dat_s1, dat_s2;
  logic clk_fall;
  logic timeout;

  logic clk_oe_q, data_oe_q;
  logic ready_q, busy_q;
  logic done_q, err_q;

  assign clk_fall = clk_p & ~clk_s2;
  assign timeout  = (to_q == TO_LAST);

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx.tx_ready = ready_q;
  assign tx.tx_busy  = busy_q;
  assign tx.tx_done  = done_q;
  assign tx.tx_error = err_q;

  // Bring both pins into clk; idle lines are high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_p  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      clk_p  <= clk_s2;
      dat_s1 <= ps2_data_in;
      dat_s2 <= dat_s1;
    end
  end

  // FSM state, counters and latched frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      to_q    <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      par_q   <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ph_q    <= ph_n;
      to_q    <= to_n;
      bit_q   <= bit_n;
      byte_q  <= byte_n;
      par_q   <= par_n;
      nack_q  <= nack_n;
    end
  end

  // Next state, counters and next data drive.
  always_comb begin
    state_n   = state_q;
    ph_n      = ph_q;
    to_n      = to_q;
    bit_n     = bit_q;
    byte_n    = byte_q;
    par_n     = par_q;
    nack_n    = nack_q;
    data_oe_n = data_oe_q;

    unique case (state_q)
      S_IDLE: begin
        data_oe_n = 1'b0;
        if (tx.tx_valid) begin
          byte_n  = tx.tx_data;
          par_n   = ~^tx.tx_data;
          bit_n   = '0;
          ph_n    = '0;
          nack_n  = 1'b0;
          state_n = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (ph_q == INH_LAST) begin
          ph_n      = '0;
          data_oe_n = 1'b1;
          state_n   = S_REQ;
        end else begin
          ph_n = ph_q + 1'b1;
        end
      end

      S_REQ: begin
        if (ph_q == REQ_LAST) begin
          ph_n    = '0;
          to_n    = '0;
          state_n = S_SEND;
        end else begin
          ph_n = ph_q + 1'b1;
        end
      end

      S_SEND: begin
        if (timeout) begin
          nack_n    = 1'b1;
          data_oe_n = 1'b0;
          state_n   = S_DONE;
        end else begin
          to_n = to_q + 1'b1;
          if (clk_fall) begin
            if (bit_q == 4'd10) begin
              nack_n    = dat_s2;
              data_oe_n = 1'b0;
              state_n   = S_WAIT;
            end else begin
              bit_n = bit_q + 4'd1;
              unique case (1'b1)
                (bit_q < 4'd8):
                  data_oe_n = ~byte_q[bit_q[2:0]];
                (bit_q == 4'd8):
                  data_oe_n = ~par_q;
                default:
                  data_oe_n = 1'b0;
              endcase
            end
          end
        end
      end

      S_WAIT: begin
        data_oe_n = 1'b0;
        if (timeout) begin
          nack_n  = 1'b1;
          state_n = S_DONE;
        end else begin
          to_n = to_q + 1'b1;
          if (clk_s2 && dat_s2)
            state_n = S_DONE;
        end
      end

      S_DONE: begin
        data_oe_n = 1'b0;
        state_n   = S_IDLE;
      end

      default: begin
        data_oe_n = 1'b0;
        state_n   = S_IDLE;
      end
    endcase
  end

  // Registered pin enables and handshake status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      clk_oe_q  <= (state_n == S_INHIBIT) ||
                   (state_n == S_REQ);
      data_oe_q <= data_oe_n;
      ready_q   <= (state_n == S_IDLE);
      busy_q    <= (state_n != S_IDLE);
      done_q    <= (state_n == S_DONE);
      err_q     <= (state_n == S_DONE) && nack_n;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table of command bytes against a
// PS/2 device model, plus timeout/reset/streaming.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 100;
  localparam int REQ = 10;
  localparam int TO  = 5000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dev_clk_lo = 1'b0;
  logic dev_data_lo = 1'b0;
  logic ps2_clk_in, ps2_data_in;
  logic ps2_clk_oe, ps2_data_oe;

  ps2_host_tx_if bus ();

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_lo);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_lo);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .REQ_CYCLES     (REQ),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx          (bus.slave)
  );

  always #20 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h",
                  nm, act, exp);
  endtask

  int cyc = 0;
  int clk_hi = 0;
  int t_crise = -1;
  int t_cfall = -1;
  int t_drise = -1;
  int t_done = -1;
  int t_rdy = -1;
  int n_done = 0;
  int n_err = 0;
  int n_acc = 0;
  int hs_bad = 0;
  logic pc = 1'b0;
  logic pd = 1'b0;
  logic pr = 1'b1;

  // Event log sampled 1 ns after each rising edge.
  always @(posedge clk) begin
    if (bus.tx_valid && bus.tx_ready) n_acc++;
    #1;
    cyc++;
    if (ps2_clk_oe) clk_hi++;
    if (ps2_clk_oe && !pc) t_crise = cyc;
    if (!ps2_clk_oe && pc) t_cfall = cyc;
    if (ps2_clk_oe && ps2_data_oe && !pd)
      t_drise = cyc;
    if (bus.tx_done) begin
      n_done++;
      t_done = cyc;
      if (bus.tx_error) n_err++;
    end
    if (bus.tx_ready && !pr) t_rdy = cyc;
    if (bus.tx_busy !== ~bus.tx_ready) hs_bad++;
    pc = ps2_clk_oe;
    pd = ps2_data_oe;
    pr = bus.tx_ready;
  end

  // Device: waits for request, clocks nf times at
  // 8 us, samples on rises; 11th clock carries ACK.
  task automatic dev_xfer(input int nf,
                          input bit ack,
                          output logic [10:0] fr,
                          output bit ok);
    fr = '0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (ps2_clk_oe) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (!ps2_clk_oe) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    #1005;
    fr[0] = ps2_data_in;
    for (int k = 1; k <= nf; k++) begin
      if (k == 11) begin
        dev_data_lo = ack;
        #2000;
      end
      dev_clk_lo = 1'b1;
      if (k == nf && nf < 11) begin
        #400;
        return;
      end
      #4000;
      dev_clk_lo = 1'b0;
      if (k <= 10) fr[k] = ps2_data_in;
      #4000;
    end
    dev_data_lo = 1'b0;
  endtask

  task automatic send(input logic [7:0] d,
                      output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (bus.tx_ready) begin ok = 1'b1; break; end
    end
    #1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = ~d;
  endtask

  task automatic wait_done(input int target,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #2;
      if (n_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    logic [10:0] frame;
    bit          err;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [10:0] fr, fr2;
    bit ok_s, ok_d, ok_d2, ok_w;
    int b_done, b_err, b_hi, b_acc, b_hs;

    vt[0] = '{8'hED, 1'b1, 11'h7DA, 1'b0};
    vt[1] = '{8'hF4, 1'b1, 11'h5E8, 1'b0};
    vt[2] = '{8'h00, 1'b1, 11'h600, 1'b0};
    vt[3] = '{8'h5A, 1'b0, 11'h6B4, 1'b1};

    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe",
        int'({ps2_clk_oe, ps2_data_oe}), 0);
    chk("rst_rdy_busy",
        int'({bus.tx_ready, bus.tx_busy}), 2);
    chk("rst_done_err",
        int'({bus.tx_done, bus.tx_error}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);

    for (int v = 0; v < 4; v++) begin
      b_done = n_done;
      b_err  = n_err;
      b_hi   = clk_hi;
      fork
        send(vt[v].data, ok_s);
        dev_xfer(11, vt[v].ack, fr, ok_d);
      join
      wait_done(b_done + 1, ok_w);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_accept", v),
          int'(ok_s), 1);
      chk($sformatf("v%0d_dev_req", v),
          int'(ok_d), 1);
      chk($sformatf("v%0d_done_seen", v),
          int'(ok_w), 1);
      chk($sformatf("v%0d_frame", v),
          int'(fr), int'(vt[v].frame));
      chk($sformatf("v%0d_done_cnt", v),
          n_done - b_done, 1);
      chk($sformatf("v%0d_err_cnt", v),
          n_err - b_err, int'(vt[v].err));
      chk($sformatf("v%0d_clk_oe_len", v),
          clk_hi - b_hi, INH + REQ);
      chk($sformatf("v%0d_data_oe_dly", v),
          t_drise - t_crise, INH);
      chk($sformatf("v%0d_rdy_after", v),
          t_rdy - t_done, 1);
      chk($sformatf("v%0d_oe_idle", v),
          int'({ps2_clk_oe, ps2_data_oe}), 0);
    end

    b_done = n_done;
    b_err  = n_err;
    send(8'hF4, ok_s);
    wait_done(b_done + 1, ok_w);
    repeat (2) @(posedge clk);
    #1;
    chk("to_done_seen", int'(ok_w), 1);
    chk("to_latency", t_done - t_cfall, TO);
    chk("to_err_cnt", n_err - b_err, 1);
    chk("to_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
    chk("to_ready", int'(bus.tx_ready), 1);
    chk("to_rdy_after", t_rdy - t_done, 1);

    b_done = n_done;
    fork
      send(8'hFF, ok_s);
      dev_xfer(4, 1'b1, fr, ok_d);
    join
    #3;
    chk("mid_busy", int'(bus.tx_busy), 1);
    chk("mid_data_oe", int'(ps2_data_oe), 0);
    reset_n = 1'b0;
    #1;
    chk("arst_oe",
        int'({ps2_clk_oe, ps2_data_oe}), 0);
    chk("arst_rdy_busy",
        int'({bus.tx_ready, bus.tx_busy}), 2);
    dev_clk_lo = 1'b0;
    #100;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    b_done = n_done;
    b_err  = n_err;
    fork
      send(8'hF4, ok_s);
      dev_xfer(11, 1'b1, fr, ok_d);
    join
    wait_done(b_done + 1, ok_w);
    repeat (3) @(posedge clk);
    chk("post_rst_frame", int'(fr), 11'h5E8);
    chk("post_rst_done", n_done - b_done, 1);
    chk("post_rst_err", n_err - b_err, 0);

    b_done = n_done;
    b_err  = n_err;
    b_acc  = n_acc;
    b_hs   = hs_bad;
    fork
      begin
        @(negedge clk);
        bus.tx_data  = 8'hAA;
        bus.tx_valid = 1'b1;
        ok_s = 1'b0;
        for (int i = 0; i < 20000; i++) begin
          @(posedge clk);
          if (bus.tx_ready) begin
            ok_s = 1'b1;
            break;
          end
        end
        #1;
        bus.tx_data = 8'h55;
        for (int i = 0; i < 20000; i++) begin
          @(posedge clk);
          if (bus.tx_ready) break;
        end
        #1;
        bus.tx_valid = 1'b0;
      end
      begin
        dev_xfer(11, 1'b1, fr, ok_d);
        dev_xfer(11, 1'b1, fr2, ok_d2);
      end
    join
    wait_done(b_done + 2, ok_w);
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_frame0", int'(fr), 11'h754);
    chk("b2b_frame1", int'(fr2), 11'h6AA);
    chk("b2b_dev_ok", int'({ok_d, ok_d2}), 3);
    chk("b2b_done_cnt", n_done - b_done, 2);
    chk("b2b_err_cnt", n_err - b_err, 0);
    chk("b2b_accepts", n_acc - b_acc, 2);
    chk("b2b_busy_rdy", hs_bad - b_hs, 0);
    chk("hs_all", hs_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
